alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//   Issues one R-type operation at a time to the shared ALU. Decodes FUNCTION to the 3-bit ALU op,
//   holds operands stable for that op's latency (single- or multi-cycle), then captures the result.
//   Sits between the decode stage (valid/ready in) and writeback (valid/ready out); one op in flight.
// PARAMETERS
//   WIDTH       32  operand/result width
//   MUL_CYCLES  4   ALU cycles for mul (>=1)
//   DIV_CYCLES  8   ALU cycles for div (>=1)
// PORTS
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous reset, active-high
//   IN_VALID   in   1      request present
//   IN_READY   out  1      sequencer can accept
//   FUNCTION   in   6      R-type funct field
//   A, B       in   WIDTH  operands
//   ALU_OP     out  3      op to ALU
//   ALU_A      out  WIDTH  operand A to ALU
//   ALU_B      out  WIDTH  operand B to ALU
//   ALU_RESULT in   WIDTH  ALU output
//   OUT_VALID  out  1      RESULT/ILLEGAL valid
//   OUT_READY  in   1      consumer accepts
//   RESULT     out  WIDTH  captured result
//   ILLEGAL    out  1      unknown FUNCTION (or div-by-zero, see CONFIGURATION)
//   BUSY       out  1      state != IDLE
// BEHAVIOUR
//   Single clock CLK; reset synchronous, active-high on RST.
//   Reset: state=IDLE, IN_READY=1, OUT_VALID=0, RESULT=0, ILLEGAL=0, BUSY=0, ALU_OP=3'b111, ALU_A=ALU_B=0, count=0.
//   Decode: 100000 add->000 | 100010 sub->001 | 100100 and->010 | 100101 or->011 | 101010 slt->100
//           011000 mul->101 | 011010 div->110 | 000000 nop->111; any other code is illegal.
//   Latency (EXEC cycles): mul=MUL_CYCLES, div=DIV_CYCLES, all others 1.
//   States:
//   - IDLE: IN_READY=1. On IN_VALID: register ALU_OP, ALU_A=A, ALU_B=B, count=latency-1 -> EXEC.
//           Illegal code: ALU_OP stays 111, RESULT=0, ILLEGAL=1, OUT_VALID=1 -> HOLD (ALU never issued).
//   - EXEC: IN_READY=0; ALU_OP/ALU_A/ALU_B held constant. count!=0: decrement.
//           count==0: RESULT<=ALU_RESULT, ILLEGAL<=0, OUT_VALID<=1 -> HOLD.
//   - HOLD: IN_READY=0; RESULT/ILLEGAL/OUT_VALID stable until OUT_READY=1. On OUT_READY: OUT_VALID<=0,
//           ALU_OP<=111 -> IDLE. Next request accepted no earlier than the following cycle.
//   Request-to-OUT_VALID: latency+1 cycles; illegal: 1 cycle.
//   Counter width = $clog2(max(MUL_CYCLES,DIV_CYCLES))+1; no wrap (loaded only in IDLE).
//   nop issues one EXEC cycle; RESULT = ALU_RESULT as sampled.
//   IN_VALID outside IDLE ignored; upstream holds the request until IN_READY.
//   OUT_READY while OUT_VALID=0 ignored.
//   RST in any state wins: in-flight op discarded, no OUT_VALID produced.
// CONFIGURATION
//   ALU_SEQ_DIVZERO_EN defined: div with B==0 is not issued; IDLE -> HOLD with RESULT=0, ILLEGAL=1,
//     OUT_VALID=1 the next cycle (same path as an illegal code).
//   Not defined: div by zero issued normally for DIV_CYCLES; RESULT = ALU_RESULT, ILLEGAL=0.
// TESTING
//   Reset: RST=1 for 2 cycles -> IN_READY=1, OUT_VALID=0, ALU_OP=111, RESULT=0, BUSY=0.
//   add: FUNCTION=100000, A=5, B=7, ALU model returns 12 -> ALU_OP=000 one cycle; OUT_VALID 2 cycles
//     after accept, RESULT=12, ILLEGAL=0.
//   mul, MUL_CYCLES=4: A=3, B=9 -> ALU_OP=101 held 4 cycles, IN_READY=0; RESULT=27 at cycle 5;
//     OUT_READY=0 for 3 cycles holds RESULT.
//   Illegal: FUNCTION=111111 -> ALU_OP stays 111; next cycle OUT_VALID=1, ILLEGAL=1, RESULT=0.
//   div B=0: with ALU_SEQ_DIVZERO_EN -> ILLEGAL=1 after 1 cycle; without -> ALU_OP=110 for 8 cycles,
//     ILLEGAL=0.
//   Reset mid-op: RST during EXEC cycle 2 of div -> IDLE next cycle, OUT_VALID never asserted; next add
//     completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Issues one R-type op at a time to a shared ALU, holding operands for the op's latency.
// Optional macro ALU_SEQ_DIVZERO_EN: reject div with B==0 as illegal instead of issuing it.
module alu_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [5:0]       FUNCTION,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [2:0]       ALU_OP,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_RESULT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ILLEGAL,
    output logic             BUSY
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
    localparam logic [2:0] OpDiv = 3'b110;
    localparam logic [2:0] OpNop = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e            state_q, state_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              illegal_q, illegal_d;
    logic              out_valid_q, out_valid_d;

    logic [2:0]        dec_op;
    logic              dec_legal;
    logic [CntW-1:0]   dec_cnt;
    logic              dec_reject;

    always_comb begin
        dec_op    = OpNop;
        dec_legal = 1'b1;
        case (FUNCTION)
            6'b100000: dec_op = OpAdd;
            6'b100010: dec_op = OpSub;
            6'b100100: dec_op = OpAnd;
            6'b100101: dec_op = OpOr;
            6'b101010: dec_op = OpSlt;
            6'b011000: dec_op = OpMul;
            6'b011010: dec_op = OpDiv;
            6'b000000: dec_op = OpNop;
            default:   dec_legal = 1'b0;
        endcase

        if (dec_op == OpMul) begin
            dec_cnt = CntW'(MUL_CYCLES - 1);
        end else if (dec_op == OpDiv) begin
            dec_cnt = CntW'(DIV_CYCLES - 1);
        end else begin
            dec_cnt = '0;
        end

        dec_reject = !dec_legal;
`ifdef ALU_SEQ_DIVZERO_EN
        dec_reject = dec_reject || (dec_legal && (dec_op == OpDiv) && (B == '0));
`endif
    end

    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        count_d     = count_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    if (dec_reject) begin
                        // Rejected requests skip the ALU entirely.
                        result_d    = '0;
                        illegal_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        alu_op_d = dec_op;
                        alu_a_d  = A;
                        alu_b_d  = B;
                        count_d  = dec_cnt;
                        state_d  = StExec;
                    end
                end
            end
            StExec: begin
                if (count_q != '0) begin
                    count_d = count_q - CntW'(1);
                end else begin
                    result_d    = ALU_RESULT;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    alu_op_d    = OpNop;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            alu_op_q    <= OpNop;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            count_q     <= '0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            count_q     <= count_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = (state_q == StIdle);
    assign BUSY      = (state_q != StIdle);
    assign ALU_OP    = alu_op_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign RESULT    = result_q;
    assign ILLEGAL   = illegal_q;
    assign OUT_VALID = out_valid_q;

endmodule
